// File: rtl/pipe_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_generator
//  Description : Produces the column stream that the playfield shifter loads
//                into its right edge. Emits SPACING empty columns followed by
//                PIPE_WIDTH solid pipe columns, repeating. Each pipe has a
//                GAP-row opening whose position comes from an 8-bit LFSR.
//                Steps once per shift_en pulse, freezes on gameover.
//  Ports       : clk           in   system clock
//                reset         in   asynchronous active-low reset
//                start         in   level, leaves IDLE when high
//                gameover      in   level, freezes the generator (sticky)
//                shift_en      in   1-cycle step pulse shared with the shifter
//                pipeRight     out  [ROWS] column loaded on next shift_en
//                pipe_start    out  1-cycle pulse after a pipe's first column
//                pipes_emitted out  [8] pipes started, wraps 255->0
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_generator #(
  parameter int          ROWS       = 16,
  parameter int          GAP        = 4,
  parameter int          SPACING    = 6,
  parameter int          PIPE_WIDTH = 2,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            gameover,
  input  logic            shift_en,
  output logic [ROWS-1:0] pipeRight,
  output logic            pipe_start,
  output logic [7:0]      pipes_emitted
);

  localparam int          MAX_RUN  = (SPACING > PIPE_WIDTH) ? SPACING : PIPE_WIDTH;
  localparam int          CW       = $clog2(MAX_RUN) + 1;
  // Gap may start anywhere from row 1 up to ROWS-GAP-1, keeping row 0 and
  // row ROWS-1 solid.
  localparam int unsigned GAP_SPAN = ROWS - GAP - 1;
  localparam logic [7:0]  SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [ROWS-1:0] GAP_ONES = {{(ROWS-GAP){1'b0}}, {GAP{1'b1}}};
  localparam logic [CW-1:0]   SPACE_LAST = CW'(SPACING - 1);
  localparam logic [CW-1:0]   PIPE_LAST  = CW'(PIPE_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GAP    = 2'd1,
    S_PIPE   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [ROWS-1:0] col_q, col_d;
  logic            ps_q, ps_d;
  logic [7:0]      pipes_q, pipes_d;

  logic [7:0]      w_lfsr_next;
  logic [31:0]     w_gap_top;
  logic [ROWS-1:0] w_pipe_col;

  assign w_lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  // The gap uses the LFSR value held before this pipe's advance.
  assign w_gap_top   = (32'(lfsr_q) % GAP_SPAN) + 32'd1;
  assign w_pipe_col  = ~(GAP_ONES << w_gap_top);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      col_q   <= '0;
      ps_q    <= 1'b0;
      pipes_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      col_q   <= col_d;
      ps_q    <= ps_d;
      pipes_q <= pipes_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    col_d   = col_q;
    ps_d    = 1'b0;
    pipes_d = pipes_q;

    if (gameover) begin
      // Everything else holds; pipe_start falls to 0 via its default.
      state_d = S_FROZEN;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end
        S_GAP: begin
          if (shift_en) begin
            if (cnt_q == SPACE_LAST) begin
              col_d   = w_pipe_col;
              cnt_d   = '0;
              state_d = S_PIPE;
              ps_d    = 1'b1;
              pipes_d = pipes_q + 8'd1;
              lfsr_d  = w_lfsr_next;
            end else begin
              col_d = '0;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_PIPE: begin
          if (shift_en) begin
            if (cnt_q == PIPE_LAST) begin
              col_d   = '0;
              cnt_d   = '0;
              state_d = S_GAP;
            end else begin
              // The pipe column stays in col_q, so the gap stays latched.
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = S_FROZEN;
        end
      endcase
    end
  end

  assign pipeRight     = col_q;
  assign pipe_start    = ps_q;
  assign pipes_emitted = pipes_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_generator
//  Description : Self-checking bench for pipe_generator. Directed vector
//                table for the opening pipes, hand sequences for freeze,
//                asynchronous reset and idle behaviour, a long back-to-back
//                shift run and randomized stimulus against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_generator;

  localparam int ROWS = 16;
  localparam int GAP  = 4;
  localparam int SP   = 6;
  localparam int PW   = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            gameover = 1'b0;
  logic            shift_en = 1'b0;
  logic [ROWS-1:0] pipeRight;
  logic            pipe_start;
  logic [7:0]      pipes_emitted;

  int total = 0;
  int bad   = 0;

  pipe_generator #(
    .ROWS(ROWS), .GAP(GAP), .SPACING(SP), .PIPE_WIDTH(PW), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .gameover(gameover),
    .shift_en(shift_en), .pipeRight(pipeRight), .pipe_start(pipe_start),
    .pipes_emitted(pipes_emitted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in the stream is tracked as a plain step count after start;
  // the column kind follows from that count modulo the period.
  bit              m_started, m_frozen, m_ps;
  int              m_n;
  logic [7:0]      m_lfsr;
  logic [ROWS-1:0] m_col;
  logic [7:0]      m_pipes;

  function automatic logic [ROWS-1:0] col_for(input logic [7:0] l);
    logic [ROWS-1:0] c;
    int top;
    c   = '1;
    top = 1 + (int'(l) % (ROWS - GAP - 1));
    for (int r = 0; r < GAP; r++) c[top + r] = 1'b0;
    return c;
  endfunction

  task automatic m_reset();
    m_started = 0; m_frozen = 0; m_ps = 0; m_n = 0;
    m_lfsr = 8'hA5; m_col = '0; m_pipes = 8'd0;
  endtask

  task automatic m_edge(input logic st, input logic go, input logic sh);
    int pos;
    m_ps = 0;
    if (m_frozen) return;
    if (go) begin
      m_frozen = 1;
    end else if (!m_started) begin
      if (st) begin m_started = 1; m_n = 0; end
    end else if (sh) begin
      m_n++;
      pos = (m_n - 1) % (SP + PW);
      if (pos == SP - 1) begin
        m_col   = col_for(m_lfsr);
        m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_pipes = m_pipes + 8'd1;
        m_ps    = 1;
      end else if (pos < SP - 1 || pos >= SP - 1 + PW) begin
        m_col = '0;
      end
    end
  endtask

  // One clock edge with the given inputs; outputs compared 1 ns after it.
  task automatic cyc(input logic st, input logic go, input logic sh);
    start = st; gameover = go; shift_en = sh;
    @(posedge clk); #1;
    m_edge(st, go, sh);
    chk("pipeRight", pipeRight, m_col);
    chk("pipe_start", pipe_start, m_ps);
    chk("pipes_emitted", pipes_emitted, m_pipes);
  endtask

  task automatic do_reset();
    start = 0; gameover = 0; shift_en = 0; reset = 0;
    #1;
    m_reset();
    chk("rst_pipeRight", pipeRight, 16'h0);
    chk("rst_pipe_start", pipe_start, 1'b0);
    chk("rst_pipes", pipes_emitted, 8'd0);
    @(posedge clk); #1;
    reset = 1;
  endtask

  typedef struct {
    logic            st, go, sh;
    logic [ROWS-1:0] right;
    logic            ps;
    logic [7:0]      cnt;
  } vec_t;

  vec_t tbl[17];

  initial begin : main
    int zeros;
    bit wrapped;
    logic [7:0] prev_cnt;

    // Directed table: start edge then 16 back-to-back shift pulses.
    tbl[0] = '{st:1'b1, go:1'b0, sh:1'b0, right:16'h0, ps:1'b0, cnt:8'd0};
    for (int k = 1; k <= 16; k++) begin
      tbl[k].st    = 1'b1;
      tbl[k].go    = 1'b0;
      tbl[k].sh    = 1'b1;
      tbl[k].right = (k == 6 || k == 7) ? 16'hFFE1 :
                     (k == 14 || k == 15) ? 16'hE1FF : 16'h0;
      tbl[k].ps    = (k == 6 || k == 14);
      tbl[k].cnt   = (k < 6) ? 8'd0 : (k < 14) ? 8'd1 : 8'd2;
    end

    do_reset();
    for (int k = 0; k <= 16; k++) begin
      start = tbl[k].st; gameover = tbl[k].go; shift_en = tbl[k].sh;
      @(posedge clk); #1;
      m_edge(tbl[k].st, tbl[k].go, tbl[k].sh);
      chk($sformatf("tbl%0d_right", k), pipeRight, tbl[k].right);
      chk($sformatf("tbl%0d_ps", k), pipe_start, tbl[k].ps);
      chk($sformatf("tbl%0d_cnt", k), pipes_emitted, tbl[k].cnt);
    end

    // Freeze mid-pipe: gameover arrives together with shift_en.
    do_reset();
    cyc(1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 1);
    cyc(1, 1, 1);
    chk("frz_hold", pipeRight, 16'hFFE1);
    chk("frz_ps", pipe_start, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1, 0, 1);
    chk("frz_after", pipeRight, 16'hFFE1);
    chk("frz_cnt", pipes_emitted, 8'd1);

    // Asynchronous reset between edges during PIPE.
    do_reset();
    cyc(1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 1);
    #3 reset = 0;
    #1;
    m_reset();
    chk("arst_right", pipeRight, 16'h0);
    chk("arst_cnt", pipes_emitted, 8'd0);
    @(posedge clk); #1;
    reset = 1;
    cyc(1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 0, 1);
    chk("arst_first_pipe", pipeRight, 16'hFFE1);

    // Idle with shift pulses but no start.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(0, 0, 1);
    chk("idle_right", pipeRight, 16'h0);

    // shift_en held high long enough for the pipe counter to wrap.
    do_reset();
    cyc(1, 0, 0);
    wrapped = 0;
    for (int k = 0; k < 2100; k++) begin
      prev_cnt = pipes_emitted;
      cyc(1, 0, 1);
      if (prev_cnt == 8'd255 && pipes_emitted == 8'd0) wrapped = 1;
      if (m_ps) begin
        zeros = 0;
        for (int r = 0; r < ROWS; r++) if (!pipeRight[r]) zeros++;
        chk("col_top", pipeRight[0], 1'b1);
        chk("col_bot", pipeRight[ROWS-1], 1'b1);
        chk("col_zeros", zeros, GAP);
      end
    end
    chk("wrap_seen", wrapped, 1'b1);

    // Randomized stimulus against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 0;
        #1;
        m_reset();
        chk("rnd_arst_right", pipeRight, 16'h0);
        chk("rnd_arst_cnt", pipes_emitted, 8'd0);
        @(posedge clk); #1;
        reset = 1;
      end else begin
        cyc(logic'($urandom_range(0, 7) == 0),
            logic'($urandom_range(0, 299) == 0),
            logic'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
